// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the two-digit 7-segment scanner
package seg_pkg;

    typedef enum logic [1:0] {
        UNI   = 2'd0,
        GAP_U = 2'd1,
        DEC   = 2'd2,
        GAP_D = 2'd3
    } state_e;

    localparam int DEF_REFRESH_DIV = 50000;
    localparam int DEF_GAP         = 2;

    // Segment patterns gfedcba indexed by digit; 10..15 are never shown and stay dark
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000,
        7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
        7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
    };

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        return SEG_LUT[d];
    endfunction

endpackage

// File: rtl/seg_dec7.sv
// seg_dec7: combinational 4-bit digit to 7-segment (gfedcba) decoder
module seg_dec7
    import seg_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    assign seg_o = seg_pattern(digit_i);

endmodule

// File: rtl/seg_scan.sv
// seg_scan: multiplexes a 0..15 value onto a two-digit display with blank gaps between digits
module seg_scan
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = DEF_REFRESH_DIV,
    parameter int GAP         = DEF_GAP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] valor,
    input  logic       cargar,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LIT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    val_q;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          tens;
    logic [3:0]    units;
    logic [3:0]    digit;
    logic [6:0]    dec_seg;
    logic          slot_last;
    logic          lit_uni, lit_dec;

    // Value register: loads on every strobe, holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) val_q <= '0;
        else if (cargar) val_q <= valor;
    end

    assign tens      = (val_q >= 4'd10);
    assign units     = tens ? val_q - 4'd10 : val_q;
    assign slot_last = (state_q == UNI || state_q == DEC) ? (cnt_q == LIT_LAST) : (cnt_q == GAP_LAST);

    // State and slot counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNI;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: advance on the last cycle of a slot and restart the counter with it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            UNI:     if (slot_last) state_d = GAP_U;
            GAP_U:   if (slot_last) state_d = DEC;
            DEC:     if (slot_last) state_d = GAP_D;
            GAP_D:   if (slot_last) state_d = UNI;
            default: state_d = UNI;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Tens digit can only be 1, so the decoder sees either units or a constant 1
    assign digit = (state_q == DEC) ? 4'd1 : units;

    seg_dec7 u_dec (
        .digit_i (digit),
        .seg_o   (dec_seg)
    );

    assign lit_uni = (state_q == UNI);
    assign lit_dec = (state_q == DEC) && tens;

    // Output decode: at most one enable, dark in gaps and for a leading-zero tens digit
    always_comb begin
        an_d  = {lit_dec, lit_uni};
        seg_d = (lit_uni || lit_dec) ? dec_seg : 7'b0000000;
    end

    // Registered outputs, one cycle behind the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            an_q  <= '0;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
